fg_cordic_vectoring: RTL and testbench

- Iterative vectoring-mode CORDIC: takes a signed (x, y) sample pair and returns its polar form, an uncompensated magnitude and an atan2 phase.
- Phase uses the same encoding as the function generator's rotation CORDIC, so results can be fed straight back as a phase word. Full scale is ±2^(BITWIDTH_PHASE-1) = ±180°, and 2^(BITWIDTH_PHASE-3) = 45°.
- Sits on the measurement/feedback side of the function generator and reuses one adder set over BITWIDTH-1 iterations, with a start/done handshake.

---
 rtl/fg_cordic_vectoring.sv | 133 +++++++++++++
 tb/tb_fg_cordic_vectoring.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fg_cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts a signed (x, y) pair into an
// uncompensated magnitude and an atan2 phase, one micro-rotation per enabled edge.
module fg_cordic_vectoring #(
    parameter int BITWIDTH       = 8,
    parameter int BITWIDTH_PHASE = 10
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             clk_en_i,
    input  logic                             start_i,
    input  logic signed [BITWIDTH-1:0]       x_i,
    input  logic signed [BITWIDTH-1:0]       y_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic        [BITWIDTH:0]         magnitude_o,
    output logic signed [BITWIDTH_PHASE-1:0] phase_o
);
    localparam int DW    = BITWIDTH + 2;
    localparam int CW    = $clog2(BITWIDTH);
    localparam int ITERS = BITWIDTH - 1;
    localparam logic signed [BITWIDTH_PHASE-1:0] QUARTER = BITWIDTH_PHASE'(2 ** (BITWIDTH_PHASE - 2));

    // Elementary angles atan(2^-i) in phase units; table matches the default widths.
    localparam logic signed [BITWIDTH_PHASE-1:0] ATAN [8] = '{
        BITWIDTH_PHASE'(128), BITWIDTH_PHASE'(76), BITWIDTH_PHASE'(40), BITWIDTH_PHASE'(20),
        BITWIDTH_PHASE'(10),  BITWIDTH_PHASE'(5),  BITWIDTH_PHASE'(3),  BITWIDTH_PHASE'(0)
    };

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                             state_q;
    logic        [CW-1:0]               iter_q;
    logic signed [DW-1:0]               x_q, y_q;
    logic signed [BITWIDTH_PHASE-1:0]   z_q;
    logic                               zero_q;
    logic                               busy_q, done_q;
    logic        [BITWIDTH:0]           mag_q;
    logic signed [BITWIDTH_PHASE-1:0]   phase_q;

    logic signed [DW-1:0]               x_ext, y_ext;
    logic signed [DW-1:0]               x_pre_d, y_pre_d;
    logic signed [BITWIDTH_PHASE-1:0]   z_pre_d;
    logic signed [DW-1:0]               x_sh, y_sh;
    logic signed [DW-1:0]               x_d, y_d;
    logic signed [BITWIDTH_PHASE-1:0]   z_d;

    assign x_ext = {{2{x_i[BITWIDTH-1]}}, x_i};
    assign y_ext = {{2{y_i[BITWIDTH-1]}}, y_i};

    // Fold the left half-plane onto the right so the iterations only need +-90 degrees of range.
    always_comb begin
        x_pre_d = x_ext;
        y_pre_d = y_ext;
        z_pre_d = '0;
        if (x_i[BITWIDTH-1]) begin
            if (!y_i[BITWIDTH-1]) begin
                x_pre_d = y_ext;
                y_pre_d = -x_ext;
                z_pre_d = QUARTER;
            end else begin
                x_pre_d = -y_ext;
                y_pre_d = x_ext;
                z_pre_d = -QUARTER;
            end
        end
    end

    always_comb begin
        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        if (!y_q[DW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + ATAN[iter_q];
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - ATAN[iter_q];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mag_q   <= '0;
            phase_q <= '0;
        end else if (clk_en_i) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        x_q     <= x_pre_d;
                        y_q     <= y_pre_d;
                        z_q     <= z_pre_d;
                        zero_q  <= (x_i == '0) && (y_i == '0);
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ITER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ITER: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (iter_q == CW'(ITERS - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        mag_q   <= zero_q ? '0 : x_d[BITWIDTH:0];
                        phase_q <= zero_q ? '0 : z_d;
                        state_q <= DONE;
                    end else begin
                        iter_q <= iter_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign magnitude_o = mag_q;
    assign phase_o     = phase_q;
endmodule

// File: tb/tb_fg_cordic_vectoring.sv
// Directed bench for fg_cordic_vectoring with hand-derived CORDIC results.
module tb_fg_cordic_vectoring;
    logic              clk;
    logic              rstn;
    logic              clk_en;
    logic              start;
    logic signed [7:0] x_in, y_in;
    logic              busy, done;
    logic        [8:0] mag;
    logic signed [9:0] phase;

    int errors = 0;
    int checks = 0;

    fg_cordic_vectoring #(.BITWIDTH(8), .BITWIDTH_PHASE(10)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .clk_en_i    (clk_en),
        .start_i     (start),
        .x_i         (x_in),
        .y_i         (y_in),
        .busy_o      (busy),
        .done_o      (done),
        .magnitude_o (mag),
        .phase_o     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic signed [7:0] x, input logic signed [7:0] y);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting only edges on which clk_en was high.
    task automatic wait_done(input bit toggle, input string tag, input int emag, input int eph);
        int  en_edges = 0;
        bit  seen     = 1'b0;
        bit  en_prev;
        for (int n = 0; n < 60 && !seen; n++) begin
            clk_en  = toggle ? ~clk_en : 1'b1;
            en_prev = clk_en;
            tick();
            if (en_prev) en_edges++;
            if (done) seen = 1'b1;
        end
        clk_en = 1'b1;
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, en_edges, 7);
        check({tag, "_mag"}, $signed({1'b0, mag}), emag);
        check({tag, "_phase"}, phase, eph);
        $display("op %s: mag=%0d phase=%0d enabled_edges=%0d", tag, mag, phase, en_edges);
    endtask

    initial begin
        bit seen_done;
        rstn   = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        x_in   = '0;
        y_in   = '0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mag", $signed({1'b0, mag}), 0);
        check("rst_phase", phase, 0);
        tick();
        rstn = 1'b1;
        tick();

        start_op(8'sd100, 8'sd0);
        check("busy_after_accept", 32'(busy), 1);
        wait_done(1'b0, "x100_y0", 166, 0);
        start_op(8'sd0, 8'sd100);
        wait_done(1'b0, "x0_y100", 165, 256);
        start_op(-8'sd128, 8'sd0);
        wait_done(1'b0, "xm128_y0", 212, -512);
        start_op(8'sd0, 8'sd0);
        wait_done(1'b0, "zero", 0, 0);
        start_op(8'sd0, -8'sd100);
        wait_done(1'b0, "x0_ym100", 166, -256);
        start_op(-8'sd100, -8'sd100);
        wait_done(1'b0, "xm100_ym100", 236, -386);
        start_op(-8'sd128, -8'sd128);
        wait_done(1'b0, "extreme", 300, -386);

        // start held through busy, then still high on the done cycle
        x_in  = 8'sd100;
        y_in  = 8'sd0;
        start = 1'b1;
        tick();
        check("held_busy", 32'(busy), 1);
        x_in = 8'sd0;
        y_in = 8'sd100;
        wait_done(1'b0, "held_no_recapture", 166, 0);
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done_low", 32'(done), 0);
        check("b2b_mag_hold", $signed({1'b0, mag}), 166);
        wait_done(1'b0, "b2b_second", 165, 256);

        // clk_en toggled during iteration, then a stretched done
        start_op(-8'sd100, -8'sd100);
        clk_en = 1'b1;
        wait_done(1'b1, "clk_en_toggle", 236, -386);
        clk_en = 1'b0;
        tick();
        check("done_stretch", 32'(done), 1);
        clk_en = 1'b1;
        tick();
        check("done_drop", 32'(done), 0);

        // asynchronous reset in the middle of an iteration
        start_op(8'sd100, 8'sd0);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_mag", $signed({1'b0, mag}), 0);
        check("midrst_phase", phase, 0);
        tick();
        rstn = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", 32'(seen_done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
